// File: rtl/roce_rnr_timer_bank_if.sv
// Command and expiry-stream bundle for the RNR retry timer bank.
// The scheduler side is the master; the timer bank is the slave.
interface roce_rnr_timer_bank_if #(
  parameter int NUM_QP   = 8,
  parameter int QP_IDX_W = $clog2(NUM_QP)
);
  logic                arm_valid;
  logic [QP_IDX_W-1:0] arm_qp;
  logic [4:0]          arm_rnr_code;
  logic                cancel_valid;
  logic [QP_IDX_W-1:0] cancel_qp;
  logic                expire_valid;
  logic                expire_ready;
  logic [QP_IDX_W-1:0] expire_qp;
  logic [NUM_QP-1:0]   active;

  modport master (
    output arm_valid, arm_qp, arm_rnr_code, cancel_valid, cancel_qp, expire_ready,
    input  expire_valid, expire_qp, active
  );

  modport slave (
    input  arm_valid, arm_qp, arm_rnr_code, cancel_valid, cancel_qp, expire_ready,
    output expire_valid, expire_qp, active
  );
endinterface

// File: rtl/roce_rnr_timer_bank.sv
// Per-QP RNR retry timers counting down on a shared 10 us tick; expiries are
// queued as pending bits and drained round-robin onto a registered valid/ready stream.
module roce_rnr_timer_bank #(
  parameter int NUM_QP      = 8,
  parameter int QP_IDX_W    = $clog2(NUM_QP),
  parameter int TICK_CYCLES = 3222
) (
  input  logic                   clk,
  input  logic                   rst_n,
  roce_rnr_timer_bank_if.slave   bus
);
  localparam int PS_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PS_W-1:0]     prescaler_reg;
  logic                tick;
  logic [16:0]         rom_ticks;
  logic [16:0]         load_count;
  logic [NUM_QP-1:0]   active_vec;
  logic [NUM_QP-1:0]   pending_vec;
  logic [NUM_QP-1:0]   take_vec;
  logic [QP_IDX_W-1:0] rr_reg;
  logic [QP_IDX_W-1:0] rr_next;
  logic [QP_IDX_W-1:0] sel_idx;
  logic [QP_IDX_W-1:0] cand_idx;
  logic                sel_found;
  logic                load_out;
  logic                expire_valid_reg;
  logic [QP_IDX_W-1:0] expire_qp_reg;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_QP) s = s - NUM_QP;
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_reg <= '0;
    end else if (prescaler_reg == PS_W'(TICK_CYCLES - 1)) begin
      prescaler_reg <= '0;
    end else begin
      prescaler_reg <= prescaler_reg + PS_W'(1);
    end
  end

  assign tick = (prescaler_reg == PS_W'(TICK_CYCLES - 1));

  // IB RNR timer encoding in 10 us units; code 0 is the longest (655.36 ms).
  always_comb begin
    rom_ticks = '0;
    case (bus.arm_rnr_code)
      5'd0:  rom_ticks = 17'd65536;
      5'd1:  rom_ticks = 17'd1;
      5'd2:  rom_ticks = 17'd2;
      5'd3:  rom_ticks = 17'd3;
      5'd4:  rom_ticks = 17'd4;
      5'd5:  rom_ticks = 17'd6;
      5'd6:  rom_ticks = 17'd8;
      5'd7:  rom_ticks = 17'd12;
      5'd8:  rom_ticks = 17'd16;
      5'd9:  rom_ticks = 17'd24;
      5'd10: rom_ticks = 17'd32;
      5'd11: rom_ticks = 17'd48;
      5'd12: rom_ticks = 17'd64;
      5'd13: rom_ticks = 17'd96;
      5'd14: rom_ticks = 17'd128;
      5'd15: rom_ticks = 17'd192;
      5'd16: rom_ticks = 17'd256;
      5'd17: rom_ticks = 17'd384;
      5'd18: rom_ticks = 17'd512;
      5'd19: rom_ticks = 17'd768;
      5'd20: rom_ticks = 17'd1024;
      5'd21: rom_ticks = 17'd1536;
      5'd22: rom_ticks = 17'd2048;
      5'd23: rom_ticks = 17'd3072;
      5'd24: rom_ticks = 17'd4096;
      5'd25: rom_ticks = 17'd6144;
      5'd26: rom_ticks = 17'd8192;
      5'd27: rom_ticks = 17'd12288;
      5'd28: rom_ticks = 17'd16384;
      5'd29: rom_ticks = 17'd24576;
      5'd30: rom_ticks = 17'd32768;
      5'd31: rom_ticks = 17'd49152;
      default: rom_ticks = '0;
    endcase
  end

  // One extra tick absorbs the partial tick period in progress at arm time.
  assign load_count = rom_ticks + 17'd1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_QP; gi = gi + 1) begin : g_qp
      logic [16:0] count_reg;
      logic        run_reg;
      logic        pend_reg;
      logic        arm_hit;
      logic        cancel_hit;
      logic        expire_hit;

      assign arm_hit    = bus.arm_valid    && (bus.arm_qp    == QP_IDX_W'(gi));
      assign cancel_hit = bus.cancel_valid && (bus.cancel_qp == QP_IDX_W'(gi));
      assign expire_hit = tick && run_reg && (count_reg == 17'd1);

      // Commands take priority over a coincident expiry; arm beats cancel.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= '0;
          run_reg   <= 1'b0;
          pend_reg  <= 1'b0;
        end else if (arm_hit) begin
          count_reg <= load_count;
          run_reg   <= 1'b1;
          pend_reg  <= 1'b0;
        end else if (cancel_hit) begin
          count_reg <= '0;
          run_reg   <= 1'b0;
          pend_reg  <= 1'b0;
        end else begin
          if (tick && run_reg) begin
            count_reg <= count_reg - 17'd1;
          end
          if (expire_hit) begin
            run_reg  <= 1'b0;
            pend_reg <= 1'b1;
          end else if (take_vec[gi]) begin
            pend_reg <= 1'b0;
          end
        end
      end

      assign active_vec[gi]  = run_reg;
      assign pending_vec[gi] = pend_reg;
      assign take_vec[gi]    = load_out && sel_found && (sel_idx == QP_IDX_W'(gi));
    end
  endgenerate

  // First pending QP at or above the round-robin pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_QP; i++) begin
      cand_idx = QP_IDX_W'(wrap_idx(int'(rr_reg), i));
      if (!sel_found && pending_vec[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  assign rr_next  = (sel_idx == QP_IDX_W'(NUM_QP - 1)) ? '0 : sel_idx + QP_IDX_W'(1);
  assign load_out = !expire_valid_reg || bus.expire_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expire_valid_reg <= 1'b0;
      expire_qp_reg    <= '0;
      rr_reg           <= '0;
    end else if (load_out) begin
      expire_valid_reg <= sel_found;
      if (sel_found) begin
        expire_qp_reg <= sel_idx;
        rr_reg        <= rr_next;
      end
    end
  end

  assign bus.expire_valid = expire_valid_reg;
  assign bus.expire_qp    = expire_qp_reg;
  assign bus.active       = active_vec;
endmodule
